// File: rtl/priority_resolver_if.sv
// priority_resolver_if: request, mask and INTA/EOI handshake bundle between the CPU side and the resolver.
interface priority_resolver_if;
   logic [7:0] ir;
   logic [7:0] imr;
   logic       inta;
   logic       eoi;
   logic       int_o;
   logic [7:0] grant;
   logic [7:0] irr;
   logic [7:0] isr;
   modport master (output ir, imr, inta, eoi, input int_o, grant, irr, isr);
   modport slave  (input ir, imr, inta, eoi, output int_o, grant, irr, isr);
endinterface

// File: rtl/priority_resolver.sv
// priority_resolver: IRR/ISR stage of an 8-level PIC with fully nested priority and INTA/EOI handshake.
// Define ROTATE_PRIORITY_EN to make each EOI rotate the just-serviced level to lowest priority.
module priority_resolver #(
   parameter bit LEVEL_TRIG = 1'b0
) (
   input logic clk,
   input logic rst_n,
   priority_resolver_if.slave bus
);
   typedef enum logic {IDLE, REQ} state_t;
   state_t state, state_n;
   logic [7:0] ir_q, irr_q, isr_q, grant_q;
   logic [7:0] pend, ack_m, clr_m, isr_n, irr_n, grant_n;
   logic [3:0] rw, rt, rn;
   logic [2:0] win, top, lp_n;
   logic       elig, ack, clr;
`ifdef ROTATE_PRIORITY_EN
   logic [2:0] lp;
`else
   localparam logic [2:0] lp = 3'd7;
`endif
   // Rank 0 is the highest priority (level lp+1); 8 means no bit set.
   function automatic logic [3:0] rank_of(input logic [7:0] v, input logic [2:0] l);
      rank_of = 4'd8;
      for (int k = 7; k >= 0; k--)
         if (v[3'(l + 3'd1 + 3'(k))]) rank_of = 4'(k);
   endfunction
   always_comb begin
      pend    = irr_q & ~bus.imr;
      rw      = rank_of(pend, lp);
      rt      = rank_of(isr_q, lp);
      win     = lp + 3'd1 + rw[2:0];
      top     = lp + 3'd1 + rt[2:0];
      elig    = rw < rt;
      ack     = (state == REQ) && bus.inta && elig;
      clr     = bus.eoi && !rt[3];
      ack_m   = ack ? 8'h01 << win : 8'h00;
      clr_m   = clr ? 8'h01 << top : 8'h00;
      isr_n   = (isr_q & ~clr_m) | ack_m;
`ifdef ROTATE_PRIORITY_EN
      lp_n    = clr ? top : lp;
`else
      lp_n    = lp;
`endif
      irr_n   = LEVEL_TRIG ? bus.ir & ~ack_m : (irr_q & ~ack_m) | (bus.ir & ~ir_q);
      rn      = rank_of(isr_n, lp_n);
      grant_n = rn[3] ? 8'h00 : 8'h01 << 3'(lp_n + 3'd1 + rn[2:0]);
      state_n = (state == IDLE) ? (elig ? REQ : IDLE) : ((bus.inta || !elig) ? IDLE : REQ);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ir_q    <= 8'h00;
         irr_q   <= 8'h00;
         isr_q   <= 8'h00;
         grant_q <= 8'h00;
      end else begin
         state   <= state_n;
         ir_q    <= bus.ir;
         irr_q   <= irr_n;
         isr_q   <= isr_n;
         grant_q <= grant_n;
      end
   end
`ifdef ROTATE_PRIORITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lp <= 3'd7;
      else lp <= lp_n;
   end
`endif
   assign bus.int_o = (state == REQ);
   assign bus.grant = grant_q;
   assign bus.irr   = irr_q;
   assign bus.isr   = isr_q;
endmodule

// File: tb/tb_priority_resolver.sv
// tb_priority_resolver: directed vectors for edge and level capture instances of priority_resolver.
module tb_priority_resolver;
   logic clk = 1'b0;
   logic rst_n;
   int checks = 0;
   int errors = 0;
   priority_resolver_if be ();
   priority_resolver_if bl ();
   priority_resolver #(.LEVEL_TRIG(1'b0)) u_edge (.clk(clk), .rst_n(rst_n), .bus(be));
   priority_resolver #(.LEVEL_TRIG(1'b1)) u_lvl  (.clk(clk), .rst_n(rst_n), .bus(bl));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic pulse_inta();
      be.inta = 1'b1;
      step();
      be.inta = 1'b0;
   endtask
   task automatic pulse_eoi();
      be.eoi = 1'b1;
      step();
      be.eoi = 1'b0;
   endtask
   task automatic restart();
      rst_n = 1'b0;
      be.ir = 8'h00;
      be.imr = 8'h00;
      step();
      rst_n = 1'b1;
      step();
   endtask
   initial begin
      rst_n = 1'b0;
      be.ir = 8'hFF; be.imr = 8'h00; be.inta = 1'b0; be.eoi = 1'b0;
      bl.ir = 8'h00; bl.imr = 8'h00; bl.inta = 1'b0; bl.eoi = 1'b0;
      step(); step();
      check("rst_int", 8'(be.int_o), 8'h00);
      check("rst_grant", be.grant, 8'h00);
      check("rst_irr", be.irr, 8'h00);
      check("rst_isr", be.isr, 8'h00);
      rst_n = 1'b1;
      step();
      check("rel_irr", be.irr, 8'hFF);
      check("rel_int_early", 8'(be.int_o), 8'h00);
      step();
      check("rel_int", 8'(be.int_o), 8'h01);
      rst_n = 1'b0;
      #1;
      check("mid_rst_int", 8'(be.int_o), 8'h00);
      check("mid_rst_irr", be.irr, 8'h00);
      be.ir = 8'h00;
      step();
      rst_n = 1'b1;
      step();
      be.ir = 8'h24;
      step(); step();
      check("fix_int", 8'(be.int_o), 8'h01);
      pulse_inta();
      check("fix_isr", be.isr, 8'h04);
      check("fix_grant", be.grant, 8'h04);
      check("fix_irr", be.irr, 8'h20);
      check("fix_int_low", 8'(be.int_o), 8'h00);
      step(); step();
      check("fix_int_hold", 8'(be.int_o), 8'h00);
      pulse_eoi();
      check("fix_eoi_isr", be.isr, 8'h00);
      check("fix_eoi_grant", be.grant, 8'h00);
      step();
      check("fix_int2", 8'(be.int_o), 8'h01);
      pulse_inta();
      check("fix_grant2", be.grant, 8'h20);
      be.ir = 8'h26;
      step(); step();
      check("nest_int", 8'(be.int_o), 8'h01);
      pulse_inta();
      check("nest_isr", be.isr, 8'h22);
      check("nest_grant", be.grant, 8'h02);
      pulse_eoi();
      check("nest_eoi_isr", be.isr, 8'h20);
      check("nest_eoi_grant", be.grant, 8'h20);
      restart();
      be.imr = 8'h08;
      step();
      be.ir = 8'h08;
      step(); step();
      check("mask_irr", be.irr, 8'h08);
      check("mask_int", 8'(be.int_o), 8'h00);
      pulse_inta();
      check("spur_irr", be.irr, 8'h08);
      check("spur_isr", be.isr, 8'h00);
      check("spur_grant", be.grant, 8'h00);
      be.imr = 8'h00;
      step();
      check("unmask_int", 8'(be.int_o), 8'h01);
      pulse_inta();
      check("unmask_grant", be.grant, 8'h08);
      restart();
      be.ir = 8'h04;
      step(); step();
      pulse_inta();
      check("rot_isr", be.isr, 8'h04);
      pulse_eoi();
      check("rot_eoi_isr", be.isr, 8'h00);
      be.ir = 8'h0E;
      step();
      check("rot_irr", be.irr, 8'h0A);
      step();
      check("rot_int", 8'(be.int_o), 8'h01);
      pulse_inta();
`ifdef ROTATE_PRIORITY_EN
      check("rot_grant", be.grant, 8'h08);
`else
      check("rot_grant", be.grant, 8'h02);
`endif
      bl.ir = 8'h40;
      step();
      check("lvl_irr", bl.irr, 8'h40);
      step();
      check("lvl_int", 8'(bl.int_o), 8'h01);
      bl.ir = 8'h00;
      step();
      check("lvl_drop_irr", bl.irr, 8'h00);
      step();
      check("lvl_drop_int", 8'(bl.int_o), 8'h00);
      check("lvl_drop_isr", bl.isr, 8'h00);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
